// File: rtl/rv32m_div_unit.sv
// rtl/rv32m_div_unit.sv - iterative RV32M DIV/DIVU/REM/REMU unit; DIV_FAST_SPECIAL_EN enables the 1-edge special-case path
module rv32m_cla32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum
);
    logic [31:0] g;
    logic [31:0] p;
    logic [31:0] c;
    logic        gg;
    logic        gp;

    // 4-bit lookahead groups; group carries skip across each group
    always_comb begin
        g  = a & b;
        p  = a ^ b;
        c  = '0;
        gg = 1'b0;
        gp = 1'b0;
        c[0] = cin;
        for (int k = 0; k < 8; k++) begin
            for (int j = 1; j < 4; j++) begin
                c[4*k+j] = g[4*k+j-1] | (p[4*k+j-1] & c[4*k+j-1]);
            end
            gg = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
            gp = p[4*k+3] & p[4*k+2] & p[4*k+1] & p[4*k];
            if (k < 7) begin
                c[4*k+4] = gg | (gp & c[4*k]);
            end
        end
        sum = p ^ c;
    end
endmodule

module rv32m_div_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result
);
    if (XLEN != 32) begin : g_bad_xlen
        $error("rv32m_div_unit: XLEN must be 32");
    end

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [XLEN-1:0]   q_q;
    logic [XLEN-1:0]   d_q;
    logic [XLEN-1:0]   r_q;
    logic              rem_sel_q;
    logic              neg_quo_q;
    logic              neg_rem_q;
    logic              out_valid_q;
    logic [XLEN-1:0]   result_q;

    logic [XLEN-1:0]   r_shift;
    logic [XLEN-1:0]   d_inv;
    logic [XLEN-1:0]   sum;
    logic              c31;
    logic              cout;
    logic              ge;
    logic [XLEN-1:0]   r_d;
    logic [XLEN-1:0]   q_d;

    logic              is_signed;
    logic              a_neg;
    logic              b_neg;
    logic [XLEN-1:0]   a_mag;
    logic [XLEN-1:0]   b_mag;
    logic              neg_quo_d;

    rv32m_cla32 u_cla (
        .a   (r_shift),
        .b   (d_inv),
        .cin (1'b1),
        .sum (sum)
    );

    // Carry out is rebuilt from bit 31 so the shared adder needs no extra port
    always_comb begin
        r_shift = {r_q[XLEN-2:0], q_q[XLEN-1]};
        d_inv   = ~d_q;
        c31     = sum[XLEN-1] ^ r_shift[XLEN-1] ^ d_inv[XLEN-1];
        cout    = (r_shift[XLEN-1] & d_inv[XLEN-1]) | (r_shift[XLEN-1] & c31)
                | (d_inv[XLEN-1] & c31);
        ge      = r_q[XLEN-1] | cout;
        r_d     = ge ? sum : r_shift;
        q_d     = {q_q[XLEN-2:0], ge};
    end

    always_comb begin
        is_signed = ~op[0];
        a_neg     = is_signed & rs1[XLEN-1];
        b_neg     = is_signed & rs2[XLEN-1];
        a_mag     = a_neg ? (~rs1 + 1'b1) : rs1;
        b_mag     = b_neg ? (~rs2 + 1'b1) : rs2;
        neg_quo_d = is_signed & (rs2 != '0) & (rs1[XLEN-1] ^ rs2[XLEN-1]);
    end

`ifdef DIV_FAST_SPECIAL_EN
    logic            special_hit;
    logic [XLEN-1:0] special_res;

    always_comb begin
        special_hit = (rs2 == '0)
                    | (is_signed & (rs1 == {1'b1, {(XLEN-1){1'b0}}}) & (rs2 == '1));
        if (rs2 == '0) begin
            special_res = op[1] ? rs1 : '1;
        end else begin
            special_res = op[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            q_q         <= '0;
            d_q         <= '0;
            r_q         <= '0;
            rem_sel_q   <= 1'b0;
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        rem_sel_q <= op[1];
                        neg_quo_q <= neg_quo_d;
                        neg_rem_q <= a_neg;
                        q_q       <= a_mag;
                        d_q       <= b_mag;
                        r_q       <= '0;
                        cnt_q     <= '0;
`ifdef DIV_FAST_SPECIAL_EN
                        if (special_hit) begin
                            result_q    <= special_res;
                            out_valid_q <= 1'b1;
                            state_q     <= S_DONE;
                        end else begin
                            state_q <= S_RUN;
                        end
`else
                        state_q   <= S_RUN;
`endif
                    end
                end
                S_RUN: begin
                    r_q   <= r_d;
                    q_q   <= q_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(XLEN - 1)) begin
                        state_q <= S_FIX;
                    end
                end
                S_FIX: begin
                    if (rem_sel_q) begin
                        result_q <= neg_rem_q ? (~r_q + 1'b1) : r_q;
                    end else begin
                        result_q <= neg_quo_q ? (~q_q + 1'b1) : q_q;
                    end
                    out_valid_q <= 1'b1;
                    state_q     <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = out_valid_q;
    assign result    = result_q;
endmodule

// File: tb/tb_rv32m_div_unit.sv
// tb/tb_rv32m_div_unit.sv - scoreboard bench for rv32m_div_unit
module tb_rv32m_div_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  op = 2'b00;
    logic [31:0] rs1 = '0;
    logic [31:0] rs2 = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] result;

    localparam int LAT = 33;
`ifdef DIV_FAST_SPECIAL_EN
    localparam int SPL = 0;
`else
    localparam int SPL = 33;
`endif

    typedef struct {
        logic [31:0] res;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;

    rv32m_div_unit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .rs1       (rs1),
        .rs2       (rs2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic monitor();
        exp_t cur;
        bit   seen;
        seen = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n || !out_valid) begin
                seen = 1'b0;
            end else if (!seen) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL spurious_out: got result %h with no request pending", result);
                end else begin
                    cur = sb.pop_front();
                    check("result", result, cur.res);
                    check("latency", 32'(cyc - cur.acc), 32'(cur.lat));
                end
                seen = 1'b1;
            end else begin
                check("hold_result", result, cur.res);
            end
        end
    endtask

    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_res, input int lat);
        int   n;
        exp_t e;
        n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        op       = o;
        rs1      = a;
        rs2      = b;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("accept_timeout", {31'b0, in_ready}, 32'd1);
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            e.res = exp_res;
            e.lat = lat;
            e.acc = cyc;
            sb.push_back(e);
            in_valid = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((sb.size() != 0 || out_valid || !in_ready) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("idle_timeout", 32'(sb.size()), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        int n;
        fork
            monitor();
        join_none

        #1;
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // in_valid pulses while busy must not disturb the running divide
        issue(2'b01, 32'd100, 32'd7, 32'd14, LAT);
        repeat (3) begin
            @(negedge clk);
            in_valid = 1'b1;
            rs1 = 32'd5;
            rs2 = 32'd1;
        end
        @(negedge clk);
        in_valid = 1'b0;
        wait_idle();

        issue(2'b11, 32'd100,        32'd7,        32'd2,        LAT); wait_idle();
        issue(2'b00, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFD, LAT); wait_idle();
        issue(2'b10, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFF, LAT); wait_idle();
        issue(2'b10, 32'd7,          32'hFFFFFFFE, 32'd1,        LAT); wait_idle();
        issue(2'b00, 32'h12345678,   32'd0,        32'hFFFFFFFF, SPL); wait_idle();
        issue(2'b01, 32'h12345678,   32'd0,        32'hFFFFFFFF, SPL); wait_idle();
        issue(2'b10, 32'hFFFFFF00,   32'd0,        32'hFFFFFF00, SPL); wait_idle();
        issue(2'b00, 32'h80000000,   32'hFFFFFFFF, 32'h80000000, SPL); wait_idle();
        issue(2'b10, 32'h80000000,   32'hFFFFFFFF, 32'd0,        SPL); wait_idle();
        issue(2'b01, 32'hFFFFFFFF,   32'd1,        32'hFFFFFFFF, LAT); wait_idle();

        // Backpressure: hold the consumer off for 5 cycles in DONE
        @(posedge clk);
        #1 out_ready = 1'b0;
        issue(2'b01, 32'd100, 32'd7, 32'd14, LAT);
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            check("bp_out_valid", {31'b0, out_valid}, 32'd1);
            check("bp_in_ready", {31'b0, in_ready}, 32'd0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_valid", {31'b0, out_valid}, 32'd0);
        check("bp_release_ready", {31'b0, in_ready}, 32'd1);
        wait_idle();

        // Reset at E10 of a signed divide: nothing may escape
        @(negedge clk);
        in_valid = 1'b1;
        op  = 2'b00;
        rs1 = 32'd1000;
        rs2 = 32'd3;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", {31'b0, out_valid}, 32'd0);
        check("midrst_result", result, 32'd0);
        check("midrst_in_ready", {31'b0, in_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        issue(2'b01, 32'd9, 32'd3, 32'd3, LAT);
        wait_idle();

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/rv32m_div_unit.md
Name: rv32m_div_unit

Overview:
- Iterative 32-bit divider for the RV32M DIV/DIVU/REM/REMU instructions. It sits beside the ALU in the execute stage.
- It feeds operand pairs into the team's 32-bit carry-lookahead adder each cycle: minuend = shifted partial remainder, addend = ~divisor magnitude, carry-in = 1.
- It consumes the adder's sum to form the next partial remainder.
- The core stalls on in_ready/out_valid while a divide is in flight.

Parameters:
- XLEN, 32, datapath width. Only 32 is legal (the adder is fixed 32-bit); any other value is an elaboration error.
- CNT_W, 6, iteration counter width. It must hold 0..32.

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous reset, active-low
- in_valid  input  1  request valid
- in_ready  output  1  unit can accept a request; high only in IDLE
- op  input  2  funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU
- rs1  input  32  dividend
- rs2  input  32  divisor
- out_valid  output  1  result valid (registered)
- out_ready  input  1  consumer accepts result
- result  output  32  quotient or remainder, selected by op

Behaviour:
- Interface (already decided): one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE, out_valid=0, result=0, counter=0, all internal registers 0. in_ready=1 after reset.
- States: IDLE, RUN, FIX, DONE.
- IDLE:
  - On in_valid && in_ready (edge E0), latch op, sign flags, |rs1| as quotient shift register Q, |rs2| as D, R=0, cnt=0; go to RUN.
  - Magnitudes apply to signed ops only (op[0]=0). The magnitude of 0x80000000 is unsigned 0x80000000.
- RUN, one restoring step per edge (E1..E32):
  - R' = {R[30:0], Q[31]}. The adder computes S = R' + ~D + 1.
  - ge = R[31] | cout. cout is derived from adder bit 31: c31 = S[31]^R'[31]^~D[31], cout = majority(R'[31], ~D[31], c31).
  - If ge: R<=S, else R<=R'. Q <= {Q[30:0], ge}. cnt++.
  - After the E32 step (cnt reaches 32), go to FIX.
- FIX (E33):
  - Negate quotient iff signed && rs2!=0 && (rs1[31]^rs2[31]).
  - Negate remainder iff signed && rs1[31].
  - result <= (op[1] ? R : Q) after correction. out_valid<=1. Go to DONE.
- DONE: hold result and out_valid stable while !out_ready. On out_valid && out_ready, out_valid<=0 and go to IDLE. A new request is accepted no earlier than the following cycle.
- Latency: first out_valid cycle follows edge E33, i.e. 33 edges after the accepting edge. Throughput is one divide per 35 cycles minimum.
- Divide by zero (natural path gives this):
  - Quotient = 0xFFFFFFFF (sign correction suppressed).
  - Remainder = rs1, including sign.
- Signed overflow, 0x80000000 / 0xFFFFFFFF: quotient = 0x80000000, remainder = 0.
- in_valid while not IDLE is ignored. Operands are sampled only at E0.
- rst_n low mid-RUN, FIX or DONE: immediate return to IDLE with out_valid=0 and result=0. No partial result escapes.

Optional Feature:
- Macro: DIV_FAST_SPECIAL_EN.
- Defined:
  - At E0, if rs2==0, or if a signed op has rs1==0x80000000 && rs2==0xFFFFFFFF, go directly to DONE with the special-case result loaded.
  - out_valid follows E0; latency is 1 edge. The adder is not exercised.
- Undefined: all cases take the 33-edge iterative path with identical results.

Test Plan:
- DIVU rs1=100, rs2=7 -> result=14, out_valid asserted exactly after edge E33. REMU with the same operands -> 2.
- DIV rs1=0xFFFFFFF9 (-7), rs2=2 -> 0xFFFFFFFD (-3). REM -> 0xFFFFFFFF (-1). REM rs1=7, rs2=-2 -> 1.
- Divide by zero: DIV/DIVU rs1=0x12345678, rs2=0 -> 0xFFFFFFFF. REM rs1=0xFFFFFF00, rs2=0 -> 0xFFFFFF00. Latency is 1 edge with DIV_FAST_SPECIAL_EN, 33 without.
- Overflow: DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000. REM -> 0. DIVU 0xFFFFFFFF / 1 -> 0xFFFFFFFF (exercises the R[31] ge path).
- Backpressure: out_ready low for 5 cycles in DONE -> result and out_valid stable and in_ready=0. Unit returns to IDLE on the cycle after out_ready rises.
- Assert rst_n low at E10 of a DIV -> out_valid=0 and result=0 immediately, in_ready=1. A fresh DIVU 9/3 then returns 3.
